interfaccia_ricezione: RTL

INTERFACCIA_RICEZIONE -- requirements
Module: interfaccia_ricezione

---
 rtl/interfaccia_ricezione.sv | 77 +++++++
 1 files changed

// File: rtl/interfaccia_ricezione.sv
// Receive side of a two-phase RDY/ACK handshake feeding a small FIFO.
// A pending message is one whose RDY toggle has not yet been answered by an ACK toggle.
module interfaccia_ricezione #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         msg_in,
  input  logic                     rdy_line,
  output logic                     ack_line,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_take,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] buf_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             rdy_seen;
  logic             ack_q;

  logic pending;
  logic full;
  logic empty;
  logic accept;
  logic pop;

  // Full is judged on the pre-edge count, so a pop at the same edge does not free a slot yet.
  assign pending = rdy_line ^ rdy_seen;
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign accept  = pending && !full;
  assign pop     = out_take && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      rdy_seen <= 1'b0;
      ack_q    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
    end else begin
      if (accept) begin
        wr_ptr   <= wr_ptr + AW'(1);
        rdy_seen <= ~rdy_seen;
        ack_q    <= ~ack_q;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (accept && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !accept) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Storage needs no reset; occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clock) begin
    if (!reset && accept) begin
      buf_mem[wr_ptr] <= msg_in;
    end
  end

  assign ack_line  = ack_q;
  assign out_data  = buf_mem[rd_ptr];
  assign out_valid = !empty;
  assign count     = cnt;

endmodule
